// File: rtl/fsm_seq_ctrl_pkg.sv
// Shared definitions for the bit-serial sequence detector controller.
package fsm_seq_ctrl_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;

    // Index of the last bit of a word, sized to the bit counter.
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fsm_seq_detector.sv
// Serial pattern detector: raises a registered flag for one cycle when the
// last WORD_W bits received since reset (or since the previous hit) equal
// expected_seq, with expected_seq[0] being the first bit received.
// Hits do not overlap: after a hit the bit history is discarded.
module fsm_seq_detector
    import fsm_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              seq_in,
    input  logic [WORD_W-1:0] expected_seq,
    output logic              seq_detected
);

    logic [WORD_W-1:0] hist;
    logic [3:0]        fill;
    logic [WORD_W-1:0] hist_next;

    // Newest bit enters at the MSB so that, after a full word, hist[0] is the oldest bit.
    assign hist_next = {seq_in, hist[WORD_W-1:1]};

    // History, fill level and hit flag; the asynchronous reset flushes back to the start state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist         <= '0;
            fill         <= '0;
            seq_detected <= 1'b0;
        end else if (fill >= 4'(WORD_W - 1) && hist_next == expected_seq) begin
            hist         <= '0;
            fill         <= '0;
            seq_detected <= 1'b1;
        end else begin
            hist         <= hist_next;
            seq_detected <= 1'b0;
            if (fill != 4'(WORD_W)) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fsm_seq_detector_ctrl.sv
// Feeds 8-bit words LSB first into a neighbouring fsm_seq_detector, programs
// its pattern, keeps it flushed whenever no bit is streaming, and counts hits.
module fsm_seq_detector_ctrl
    import fsm_seq_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic              clock0,
    input  logic              reset_n,
    input  logic              cfg_we,
    input  logic [WORD_W-1:0] cfg_pattern,
    input  logic              start,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_seq_in,
    output logic [WORD_W-1:0] det_expected_seq,
    output logic              det_reset,
    input  logic              det_seq_detected,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [CNT_W-1:0]  match_count
);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] pattern;
    logic [WORD_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic [LEN_W-1:0]  words_left;
    logic              accept;
    logic              last_bit;
    logic              more_words;
    logic              counting;

    // Match counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign det_expected_seq = pattern;
    assign last_bit         = (bit_idx == BIT_LAST);
    assign more_words       = (words_left != '0);
    assign accept           = in_ready & in_valid;
    assign counting         = (state == ST_SHIFT) || (state == ST_DRAIN);

    // Next-state and handshake/stream outputs, decoded from the current state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        det_seq_in = 1'b0;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (num_words != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                det_seq_in = shreg[bit_idx];
                if (last_bit) begin
                    // Offering the next word on bit 7 keeps the stream gapless.
                    in_ready = more_words;
                    if (!(more_words && in_valid)) begin
                        next_state = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                next_state = more_words ? ST_FETCH : ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // State, pattern, detector flush, sticky underrun and match counter.
    always_ff @(posedge clock0) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pattern     <= '0;
            match_count <= '0;
            underrun    <= 1'b0;
            det_reset   <= 1'b1;
        end else begin
            state <= next_state;
            // Registered from next_state so the detector is live only in SHIFT/DRAIN.
            det_reset <= (next_state == ST_IDLE) || (next_state == ST_FETCH) ||
                         (next_state == ST_DONE);
            if (state == ST_IDLE) begin
                if (cfg_we) begin
                    pattern <= cfg_pattern;
                end
                if (start) begin
                    match_count <= '0;
                    underrun    <= 1'b0;
                end
            end else if (counting && det_seq_detected) begin
                match_count <= sat_inc(match_count);
            end
            if (state == ST_DRAIN && more_words) begin
                underrun <= 1'b1;
            end
        end
    end

    // Run length and bit position within the current word.
    always_ff @(posedge clock0) begin
        if (!reset_n) begin
            words_left <= '0;
            bit_idx    <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                words_left <= num_words;
            end else if (accept) begin
                words_left <= words_left - 1'b1;
            end
            if (accept) begin
                bit_idx <= '0;
            end else if (state == ST_SHIFT) begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    // Word being serialised; loaded on every accepted handshake.
    always_ff @(posedge clock0) begin
        if (accept) begin
            shreg <= in_data;
        end
    end

endmodule

// File: tb/tb_fsm_seq_detector_ctrl.sv
// Bench for the controller wired to a detector instance.
module tb_fsm_seq_detector_ctrl;
    import fsm_seq_ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int LEN_W = 8;

    logic             clock0 = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_we = 1'b0;
    logic [7:0]       cfg_pattern = 8'h00;
    logic             start = 1'b0;
    logic [LEN_W-1:0] num_words = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready, det_seq_in, det_reset, det_seq_detected;
    logic [7:0]       det_expected_seq;
    logic             busy, done, underrun;
    logic [CNT_W-1:0] match_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        bit urun;
        int done_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] words[$];
    int         valid_from[$];

    bit               obs_done;
    int               obs_done_cyc, obs_first_rdy, obs_busy_cyc, obs_dres_lo;
    logic [CNT_W-1:0] obs_cnt;
    logic             obs_urun;

    always #5 clock0 = ~clock0;

    fsm_seq_detector_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clock0(clock0), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .start(start), .num_words(num_words), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .det_seq_in(det_seq_in), .det_expected_seq(det_expected_seq),
        .det_reset(det_reset), .det_seq_detected(det_seq_detected), .busy(busy),
        .done(done), .underrun(underrun), .match_count(match_count)
    );

    fsm_seq_detector det (
        .clk(clock0), .reset(det_reset), .seq_in(det_seq_in),
        .expected_seq(det_expected_seq), .seq_detected(det_seq_detected)
    );

    task automatic program_pattern(input logic [7:0] p);
        @(posedge clock0); #1;
        cfg_we = 1'b1; cfg_pattern = p;
        @(posedge clock0); #1;
        cfg_we = 1'b0;
    endtask

    // Start in cycle 0, serve words[] (word i not valid before cycle valid_from[i]),
    // record what the DUT shows until done or the budget runs out.
    task automatic run(input logic [LEN_W-1:0] n, input int budget);
        int idx = 0;
        obs_done = 0; obs_done_cyc = -1; obs_first_rdy = -1;
        obs_busy_cyc = 0; obs_dres_lo = 0;
        @(posedge clock0); #1;
        start = 1'b1; num_words = n;
        for (int c = 0; c < budget && !obs_done; c++) begin
            if (c > 0) begin
                @(posedge clock0); #1;
                start = 1'b0;
            end
            in_valid = (idx < words.size()) ? (c >= valid_from[idx]) : 1'b0;
            in_data  = (idx < words.size()) ? words[idx] : 8'h00;
            @(negedge clock0);
            if (busy) obs_busy_cyc++;
            if (!det_reset) obs_dres_lo++;
            if (in_ready && obs_first_rdy < 0) obs_first_rdy = c;
            if (in_ready && in_valid) idx++;
            if (done) begin
                obs_done = 1; obs_done_cyc = c; obs_cnt = match_count; obs_urun = underrun;
            end
        end
        @(posedge clock0); #1;
        start = 1'b0; in_valid = 1'b0;
        words.delete(); valid_from.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock0);
        @(negedge clock0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL reset_det_reset got %b want 1", det_reset); end
        checks++; if ({in_ready, det_seq_in, done, underrun} !== 4'b0000) begin errors++; $display("FAIL reset_outs got %b want 0000", {in_ready, det_seq_in, done, underrun}); end
        checks++; if (match_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
        checks++; if (det_expected_seq !== 8'h00) begin errors++; $display("FAIL reset_pattern got %h want 00", det_expected_seq); end
        @(posedge clock0); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_word();
        exp_t e;
        program_pattern(8'hA5);
        checks++; if (det_expected_seq !== 8'hA5) begin errors++; $display("FAIL cfg_load got %h want a5", det_expected_seq); end
        words.push_back(8'hA5); valid_from.push_back(0);
        sb.push_back('{cnt: 1, urun: 1'b0, done_cyc: 11});
        run(1, 100);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_done_cyc != e.done_cyc) begin errors++; $display("FAIL single_done_cyc got %0d want %0d", obs_done_cyc, e.done_cyc); end
        checks++; if (obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL single_count got %0d want %0d", obs_cnt, e.cnt); end
        checks++; if (obs_urun !== e.urun) begin errors++; $display("FAIL single_underrun got %b want %b", obs_urun, e.urun); end
        checks++; if (obs_first_rdy != 1) begin errors++; $display("FAIL single_first_ready got %0d want 1", obs_first_rdy); end
        checks++; if (obs_busy_cyc != 11) begin errors++; $display("FAIL single_busy_cycles got %0d want 11", obs_busy_cyc); end
        checks++; if (obs_dres_lo != 9) begin errors++; $display("FAIL single_det_reset_low got %0d want 9", obs_dres_lo); end
    endtask

    task automatic test_bit_order();
        exp_t e;
        program_pattern(8'h01);
        words.push_back(8'h80); valid_from.push_back(0);
        sb.push_back('{cnt: 0, urun: 1'b0, done_cyc: 11});
        run(1, 100);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL bit_order_count got %0d want %0d", obs_cnt, e.cnt); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        program_pattern(8'hFF);
        words.push_back(8'hFF); words.push_back(8'hFF); words.push_back(8'h00);
        repeat (3) valid_from.push_back(0);
        sb.push_back('{cnt: 2, urun: 1'b0, done_cyc: 27});
        run(3, 200);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_done_cyc != e.done_cyc) begin errors++; $display("FAIL b2b_done_cyc got %0d want %0d", obs_done_cyc, e.done_cyc); end
        checks++; if (obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_cnt, e.cnt); end
        checks++; if (obs_urun !== e.urun) begin errors++; $display("FAIL b2b_underrun got %b want %b", obs_urun, e.urun); end
        checks++; if (obs_busy_cyc != 27) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 27", obs_busy_cyc); end
    endtask

    task automatic test_zero_words();
        exp_t e;
        sb.push_back('{cnt: 0, urun: 1'b0, done_cyc: 1});
        run(0, 50);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_done_cyc != e.done_cyc) begin errors++; $display("FAIL zero_done_cyc got %0d want %0d", obs_done_cyc, e.done_cyc); end
        checks++; if (obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL zero_count got %0d want %0d", obs_cnt, e.cnt); end
        checks++; if (obs_first_rdy != -1) begin errors++; $display("FAIL zero_in_ready got cycle %0d want none", obs_first_rdy); end
    endtask

    task automatic test_underrun();
        exp_t e;
        program_pattern(8'h0F);
        words.push_back(8'h0F); valid_from.push_back(0);
        words.push_back(8'h0F); valid_from.push_back(12);
        sb.push_back('{cnt: 2, urun: 1'b1, done_cyc: 22});
        run(2, 200);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_done_cyc != e.done_cyc) begin errors++; $display("FAIL gap_done_cyc got %0d want %0d", obs_done_cyc, e.done_cyc); end
        checks++; if (obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL gap_count got %0d want %0d", obs_cnt, e.cnt); end
        checks++; if (obs_urun !== e.urun) begin errors++; $display("FAIL gap_underrun got %b want %b", obs_urun, e.urun); end
    endtask

    task automatic test_cfg_while_busy();
        exp_t e;
        program_pattern(8'hA5);
        words.push_back(8'h3C); valid_from.push_back(0);
        sb.push_back('{cnt: 0, urun: 1'b0, done_cyc: 11});
        fork
            begin
                repeat (3) @(posedge clock0);
                #1; cfg_we = 1'b1; cfg_pattern = 8'h3C;
                @(posedge clock0); #1; cfg_we = 1'b0;
            end
        join_none
        run(1, 100);
        e = sb.pop_front();
        checks++; if (det_expected_seq !== 8'hA5) begin errors++; $display("FAIL busy_cfg_pattern got %h want a5", det_expected_seq); end
        checks++; if (!obs_done || obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL busy_cfg_count got %0d want %0d", obs_cnt, e.cnt); end
        checks++; if (obs_urun !== e.urun) begin errors++; $display("FAIL busy_cfg_underrun got %b want %b", obs_urun, e.urun); end
    endtask

    task automatic test_saturate();
        exp_t e;
        program_pattern(8'hA5);
        for (int i = 0; i < 20; i++) begin
            words.push_back(8'hA5); valid_from.push_back(0);
        end
        sb.push_back('{cnt: (1 << CNT_W) - 1, urun: 1'b0, done_cyc: 8 * 20 + 3});
        run(20, 400);
        e = sb.pop_front();
        checks++; if (!obs_done || obs_done_cyc != e.done_cyc) begin errors++; $display("FAIL sat_done_cyc got %0d want %0d", obs_done_cyc, e.done_cyc); end
        checks++; if (obs_cnt !== CNT_W'(e.cnt)) begin errors++; $display("FAIL sat_count got %0d want %0d", obs_cnt, e.cnt); end
    endtask

    task automatic test_reset_midrun();
        bit seen_done = 0;
        program_pattern(8'h0F);
        @(posedge clock0); #1;
        start = 1'b1; num_words = 2; in_valid = 1'b1; in_data = 8'h0F;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock0); #1;
            start = 1'b0;
        end
        @(negedge clock0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
        reset_n = 1'b0;
        @(posedge clock0); #1;
        reset_n = 1'b1;
        @(negedge clock0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy got %b want 0", busy); end
        checks++; if (det_reset !== 1'b1) begin errors++; $display("FAIL midrun_reset_det got %b want 1", det_reset); end
        checks++; if (match_count !== '0 || done !== 1'b0) begin errors++; $display("FAIL midrun_reset_state got count %0d done %b want 0 0", match_count, done); end
        for (int c = 0; c < 30; c++) begin
            @(negedge clock0);
            if (done) seen_done = 1;
        end
        checks++; if (seen_done) begin errors++; $display("FAIL midrun_no_done got done want none"); end
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_bit_order();
        test_back_to_back();
        test_zero_words();
        test_underrun();
        test_cfg_while_busy();
        test_saturate();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_seq_detector_ctrl.md
# fsm_seq_detector_ctrl

Controller that feeds a stream of 8-bit words, bit-serially and LSB first, into a sibling `fsm_seq_detector` instance. It also programs that detector's expected pattern, keeps the detector flushed outside active runs, and counts reported matches. It sits between a valid/ready word source and the detector, and the detector is instantiated beside it at the same level.

## Interface
Parameters:
- `CNT_W`, 16: width of `match_count`. The counter saturates at all-ones.
- `LEN_W`, 8: width of `num_words` and of the internal words-remaining counter.

Ports:
- `clock0`  in  1  single clock; every flop is on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cfg_we`  in  1  pattern write strobe; honoured only in IDLE.
- `cfg_pattern`  in  8  pattern captured on `cfg_we`.
- `start`  in  1  run request; honoured only in IDLE.
- `num_words`  in  LEN_W  number of words in the run; sampled together with `start`.
- `in_valid`  in  1  source word valid.
- `in_data`  in  8  source word.
- `in_ready`  out  1  controller accepts `in_data` in this cycle.
- `det_seq_in`  out  1  drives the detector's `seq_in`.
- `det_expected_seq`  out  8  drives the detector's `expected_seq`; equals the pattern register.
- `det_reset`  out  1  registered, active-high; drives the detector's async `reset`.
- `det_seq_detected`  in  1  the detector's registered `seq_detected`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `underrun`  out  1  sticky flag: a word gap flushed the detector during this run.
- `match_count`  out  CNT_W  matches counted in the current or last run.

## Operation
- Reset values (`reset_n`=0 at an edge): state IDLE, pattern 0x00, `match_count` 0, `underrun` 0, `det_reset` 1, `in_ready` 0, `det_seq_in` 0, `done` 0. The same applies mid-run: the run is aborted and no `done` is issued.
- Register `det_reset` is loaded each cycle with 1 when next_state ∈ {IDLE, FETCH, DONE}, else 0. The detector is therefore held at S0 with a cleared flag whenever no bit is being streamed.
- IDLE:
  - `cfg_we` loads the pattern.
  - `start` with `num_words`≠0: load words_left, clear `match_count` and `underrun`, go to FETCH.
  - `start` with `num_words`=0: go directly to DONE; the count is cleared.
- FETCH:
  - `in_ready`=1.
  - On `in_valid`: load the shift register, set bit_idx to 0, decrement words_left, go to SHIFT.
- SHIFT:
  - `det_seq_in` = shreg[bit_idx]; bit_idx increments each cycle.
  - `in_ready`=1 only when bit_idx=7 and words_left>0.
  - At bit_idx=7, with an accepted word: reload, set bit_idx to 0, stay in SHIFT. This gives a gapless stream.
  - Otherwise go to DRAIN.
- DRAIN:
  - One cycle; `det_seq_in`=0, `in_ready`=0.
  - Then go to DONE if words_left=0. Otherwise set `underrun` and go to FETCH; the detector is flushed and any partial match is lost.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Counting: `match_count` increments (saturating) in any cycle where state ∈ {SHIFT, DRAIN} and `det_seq_detected`=1.
  - DRAIN captures the flag produced by the final bit.
  - In a gapless stream, a match ending on bit 7 is counted at bit 0 of the next word.
- Matches are non-overlapping; the detector returns to S0 after a hit. Patterns spanning word boundaries are detected only in a gapless stream.
- `start`/`cfg_we` are ignored while `busy`. `in_valid` is ignored when `in_ready`=0.

## Timing
- With `start` at cycle 0 and `in_valid` held high:
  - FETCH and first accept at cycle 1.
  - SHIFT at cycles 2..8N+1.
  - DRAIN at cycle 8N+2.
  - `done` at cycle 8N+3.
  - `busy` is high for cycles 1..8N+3.
- `det_reset` is 0 exactly during SHIFT/DRAIN cycles, because it is registered from next_state.
- Each word gap costs 1 DRAIN cycle, plus at least 1 FETCH cycle, plus the wait for `in_valid`.
- `match_count` is final and stable when `done`=1.

## Structure
- Shared package `fsm_seq_ctrl_pkg`: state encoding (IDLE, FETCH, SHIFT, DRAIN, DONE; 3 bits), `WORD_W`=8, bit-index width 3.
- No sub-module is needed: a single always-block FSM plus a datapath (shift register, counters).
- The test bench instantiates `fsm_seq_detector_ctrl` together with a `fsm_seq_detector` instance.

## Test plan
- Pattern 0xA5, N=1, word 0xA5 → `match_count`=1, `done` at cycle 11, `underrun`=0.
- Pattern 0xFF, N=3, gapless words 0xFF,0xFF,0x00 → `match_count`=2, `done` at cycle 27.
- Pattern 0x0F, N=2, word 0x0F, then `in_valid` low for 3 cycles, then 0x0F → `match_count`=2, `underrun`=1.
- `start` with N=0 → `done` on cycle 1, `match_count`=0, no `in_ready`.
- `cfg_we` with 0x3C while busy → pattern unchanged; a second run with 0x3C data counts 0.
- `reset_n`=0 at cycle 6 of a run → next cycle shows IDLE, `det_reset`=1, `match_count`=0, no `done`.
